// File: rtl/cpu_clock_ctrl.sv
// Processor clock-enable generator: divides clk_in into single-cycle cpu_ce ticks with run/halt/step control.
// Latency: cpu_ce is combinational from the registered divider count; first tick lands div_q+1 cycles after entry.
// Backpressure: none; divisor writes outside HALT are dropped and flagged with a one-cycle cfg_err pulse.
//
// Ports:
//   clk_in, reset_n          - system clock, async active-low reset
//   run, halt, step          - control requests (priority halt > run > step)
//   cfg_wr, div_in           - divisor write, accepted only in HALT
//   count_clr                - synchronous clear of tick_count
//   cpu_ce                   - processor clock enable, one cycle per tick
//   state                    - 00 HALT, 01 RUN, 10 STEP
//   step_done, cfg_err       - one-cycle status pulses
//   tick_count               - number of cpu_ce pulses issued (wraps)
module cpu_clock_ctrl #(
   parameter int DIV_W   = 8,
   parameter int CNT_W   = 32,
   parameter int DEF_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             run,
   input  logic             halt,
   input  logic             step,
   input  logic             cfg_wr,
   input  logic [DIV_W-1:0] div_in,
   input  logic             count_clr,
   output logic             cpu_ce,
   output logic [1:0]       state,
   output logic             step_done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] tick_count
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10
   } state_t;

   state_t           st;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic             at_term;

   assign at_term = (cnt == div_q);
   // halt suppresses the tick in the very cycle it is requested.
   assign cpu_ce  = (st != S_HALT) && at_term && !halt;
   assign state   = st;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         st         <= S_HALT;
         div_q      <= DIV_W'(DEF_DIV);
         cnt        <= '0;
         tick_count <= '0;
         step_done  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         step_done <= 1'b0;
         cfg_err   <= 1'b0;

         // Clear wins over a coinciding tick.
         if (count_clr)
            tick_count <= '0;
         else if (cpu_ce)
            tick_count <= tick_count + CNT_W'(1);

         case (st)
            S_HALT: begin
               cnt <= '0;
               // A write alongside run/step lands in time to govern the first tick.
               if (cfg_wr)
                  div_q <= div_in;
               if (!halt && run)
                  st <= S_RUN;
               else if (!halt && step)
                  st <= S_STEP;
            end
            S_RUN: begin
               cfg_err <= cfg_wr;
               if (halt) begin
                  st  <= S_HALT;
                  cnt <= '0;
               end else if (at_term) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            S_STEP: begin
               cfg_err <= cfg_wr;
               if (halt) begin
                  // Abort: no tick was issued, so no completion pulse.
                  st  <= S_HALT;
                  cnt <= '0;
               end else if (cpu_ce) begin
                  st        <= S_HALT;
                  cnt       <= '0;
                  step_done <= 1'b1;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            default: begin
               st  <= S_HALT;
               cnt <= '0;
            end
         endcase
      end
   end

endmodule
